mod_phase_gen: RTL and testbench
================================

# mod_phase_gen

Phase-accumulator address generator for the configurable modulator; sits directly upstream of the waveform ROM and drives its `addr` input. It consumes one data bit per symbol through a valid/ready handshake. It produces one ROM address per clock, applying ASK, FSK or BPSK according to the configuration. It also emits gating and strobe signals aligned with the ROM's one-cycle read latency.

## Interface
- `ADDR_WIDTH`, 8, ROM address width; must equal the ROM's `ADDR_WIDTH`.
- `PHASE_WIDTH`, 24, accumulator width; must be ≥ `ADDR_WIDTH`.
- `SPS_WIDTH`, 16, width of the samples-per-symbol count.
- `clk` in 1: single clock, shared with the ROM.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: run enable.
- `cfg_load` in 1: capture `cfg_*` into the shadow registers; honoured only in IDLE.
- `cfg_mode` in 2: 00 carrier, 01 ASK, 10 FSK, 11 BPSK.
- `cfg_fcw0` in PHASE_WIDTH: frequency control word for bit 0, and for all bits in non-FSK modes.
- `cfg_fcw1` in PHASE_WIDTH: frequency control word for bit 1 in FSK mode.
- `cfg_sps` in SPS_WIDTH: samples per symbol; 0 is treated as 1.
- `bit_in` in 1: symbol data.
- `bit_valid` in 1: `bit_in` is valid.
- `bit_ready` out 1: combinational; equals `en & (state==IDLE | cnt==0)`.
- `rom_addr` out ADDR_WIDTH: registered address to the ROM.
- `addr_valid` out 1: `rom_addr` holds a live sample.
- `sym_strobe` out 1: `rom_addr` holds the last sample of a symbol.
- `q_valid` out 1: `addr_valid` delayed 1 cycle; aligned with ROM `q`.
- `amp_gate` out 1: amplitude enable aligned with ROM `q`.
- `underrun` out 1: one-cycle pulse when a symbol ends while `en=1` and no bit is offered.

## Operation
- The configuration shadow registers (mode, fcw0, fcw1, sps) drive all behaviour; the live `cfg_*` inputs are used only at capture.
- A handshake occurs on an edge with `bit_valid & bit_ready`.
- The current bit `b` is held until the next handshake.
- State IDLE:
  - `addr_valid` goes to 0 on the next edge.
  - On a handshake: issue sample 0 of the new symbol, set `cnt <= sps-1`, go to RUN.
  - `cfg_load` captures the configuration.
- State RUN, on each edge:
  - If `en=0`: go to IDLE, `addr_valid <= 0`, `cnt <= 0`. The symbol is truncated and no underrun is flagged.
  - Else if `cnt != 0`: issue a sample with `b`, `cnt <= cnt-1`.
  - Else, if a handshake occurs: latch the new bit, issue its sample 0, `cnt <= sps-1`. Symbols run back-to-back with no gap.
  - Else (`cnt==0`, no handshake): go to IDLE, `addr_valid <= 0`, `underrun <= 1` for one cycle.
- Issuing a sample on an edge:
  - `rom_addr <= P[PHASE_WIDTH-1 -: ADDR_WIDTH] + ((mode==BPSK && b) ? 2^(ADDR_WIDTH-1) : 0)`, truncated mod 2^ADDR_WIDTH.
  - `P <= P + ((mode==FSK && b) ? fcw1 : fcw0)`, wrapping mod 2^PHASE_WIDTH.
  - `addr_valid <= 1`.
  - `sym_strobe <= (next cnt == 0)`.
  - `b` here is the bit of the sample being issued, including a bit newly latched on that edge.
- The accumulator `P` is never cleared except by `rst`. Phase is continuous across symbols, FSK switches and IDLE periods.
- `amp_gate`: registered one cycle after the sample issue. It equals `addr_valid & (mode != ASK | b_issued)`.
- `cfg_load` while in RUN is ignored; there is no partial update.
- Carrier mode consumes bits with normal timing but ignores their value.

## Timing
- Reset values: state IDLE, `P=0`, `cnt=0`, `rom_addr=0`, `addr_valid=0`, `sym_strobe=0`, `q_valid=0`, `amp_gate=0`, `underrun=0`. Shadow registers: mode 00, fcw0 = fcw1 = 0, sps = 1.
- The first `rom_addr` is valid in the cycle after the accepting edge.
- ROM `q`, `q_valid` and `amp_gate` follow one cycle later.
- Each symbol produces exactly `max(sps,1)` consecutive valid addresses.
- `rst` mid-symbol returns every register to its reset value on that edge. `bit_ready` is 0 in the cycle after reset only if `en=0`.
- If `en` falls on the same edge as `cnt==0`, the `en=0` rule wins: no handshake, no underrun.

## Structure
- Package `mod_pkg` holds:
  - The mode encodings `MODE_CARRIER`, `MODE_ASK`, `MODE_FSK`, `MODE_BPSK`.
  - The state enum (IDLE, RUN).
- Sub-module `phase_acc` holds `P`, the FCW select, the BPSK offset add and the address slice. The FSM, counter, handshake and delay taps stay in the top module.

## Test plan
- Reset, FCW, period and underrun: set fcw0=0x010000, sps=4, mode carrier; send bit 1.
  - `rom_addr` must read 0, 1, 2, 3.
  - `sym_strobe` is high on the 4th sample.
  - `underrun` pulses on the next edge, then `addr_valid` = 0.
- FSK phase continuity: fcw0=0x010000, fcw1=0x020000, sps=2; send bits 0, 1, 0 back-to-back.
  - Addresses must be 0, 1, 2, 4, 6, 7.
  - `bit_ready` must be high exactly on the last-sample cycles.
- BPSK with wrap: fcw0=0x100000, sps=3, P preloaded to 0xF00000 by running; send bit 1.
  - Addresses must be the phase MSBs + 0x80, mod 256, e.g. 0xF0 → 0x70, then 0x00 → 0x80.
- ASK gating: mode ASK, sps=2; send bits 1, 0.
  - `amp_gate` must read 1, 1, 0, 0, aligned with `q_valid`, one cycle after the addresses.
- Enable drop and config locking: drop `en` mid-symbol with sps=8 after 3 samples.
  - `addr_valid` falls the next cycle, with no `underrun`.
  - `cfg_load` pulsed during RUN must leave sps unchanged.
  - `cfg_sps=0` must yield 1-sample symbols.
- Reset mid-symbol: assert `rst` during sample 2 of 5.
  - All outputs must be 0 on the following cycle, with `P=0`.

Source files
------------

// File: rtl/mod_pkg.sv
// Shared encodings for the modulator phase/address generator.
package mod_pkg;

    localparam logic [1:0] MODE_CARRIER = 2'b00;
    localparam logic [1:0] MODE_ASK     = 2'b01;
    localparam logic [1:0] MODE_FSK     = 2'b10;
    localparam logic [1:0] MODE_BPSK    = 2'b11;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

endpackage

// File: rtl/phase_acc.sv
// Phase accumulator: FCW select, BPSK half-turn offset and ROM address slice.
module phase_acc
    import mod_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned PHASE_WIDTH = 24
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   issue_i,
    input  logic                   bit_i,
    input  logic [1:0]             mode_i,
    input  logic [PHASE_WIDTH-1:0] fcw0_i,
    input  logic [PHASE_WIDTH-1:0] fcw1_i,
    output logic [ADDR_WIDTH-1:0]  addr_o
);

    localparam logic [ADDR_WIDTH-1:0] HalfTurn = {1'b1, {(ADDR_WIDTH-1){1'b0}}};

    logic [PHASE_WIDTH-1:0] phase_q, phase_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [PHASE_WIDTH-1:0] fcw;
    logic [ADDR_WIDTH-1:0]  offset;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= '0;
            addr_q  <= '0;
        end else begin
            phase_q <= phase_d;
            addr_q  <= addr_d;
        end
    end

    // Address comes from the pre-increment phase, so sample 0 uses the phase left by the last issue.
    always_comb begin
        fcw     = (mode_i == MODE_FSK && bit_i) ? fcw1_i : fcw0_i;
        offset  = (mode_i == MODE_BPSK && bit_i) ? HalfTurn : '0;
        phase_d = phase_q;
        addr_d  = addr_q;
        if (issue_i) begin
            addr_d  = phase_q[PHASE_WIDTH-1 -: ADDR_WIDTH] + offset;
            phase_d = phase_q + fcw;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/mod_phase_gen.sv
// Symbol-paced ROM address generator: handshake, symbol counter, config shadow and ROM-aligned taps.
module mod_phase_gen
    import mod_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned PHASE_WIDTH = 24,
    parameter int unsigned SPS_WIDTH   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   cfg_load_i,
    input  logic [1:0]             cfg_mode_i,
    input  logic [PHASE_WIDTH-1:0] cfg_fcw0_i,
    input  logic [PHASE_WIDTH-1:0] cfg_fcw1_i,
    input  logic [SPS_WIDTH-1:0]   cfg_sps_i,
    input  logic                   bit_in_i,
    input  logic                   bit_valid_i,
    output logic                   bit_ready_o,
    output logic [ADDR_WIDTH-1:0]  rom_addr_o,
    output logic                   addr_valid_o,
    output logic                   sym_strobe_o,
    output logic                   q_valid_o,
    output logic                   amp_gate_o,
    output logic                   underrun_o
);

    state_e state_q, state_d;

    logic [1:0]             mode_q;
    logic [PHASE_WIDTH-1:0] fcw0_q, fcw1_q;
    logic [SPS_WIDTH-1:0]   sps_q, sps_eff;

    logic [SPS_WIDTH-1:0] cnt_q, cnt_d;
    logic                 bit_q, bit_d;
    logic                 addr_valid_q, addr_valid_d;
    logic                 sym_strobe_q, sym_strobe_d;
    logic                 q_valid_q, q_valid_d;
    logic                 amp_gate_q, amp_gate_d;
    logic                 underrun_q, underrun_d;
    logic                 issue, handshake, cnt_zero;

    assign cnt_zero    = (cnt_q == '0);
    assign bit_ready_o = en_i & ((state_q == StIdle) | cnt_zero);
    assign handshake   = bit_valid_i & bit_ready_o;
    assign sps_eff     = (sps_q == '0) ? SPS_WIDTH'(1) : sps_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (handshake) state_d = StRun;
            StRun: begin
                if (!en_i) begin
                    state_d = StIdle;
                end else if (cnt_zero && !handshake) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Dropping en wins over both the last-sample handshake and the underrun flag.
    always_comb begin
        issue      = 1'b0;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        underrun_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (handshake) begin
                    issue = 1'b1;
                    bit_d = bit_in_i;
                    cnt_d = sps_eff - SPS_WIDTH'(1);
                end
            end
            StRun: begin
                if (!en_i) begin
                    cnt_d = '0;
                end else if (!cnt_zero) begin
                    issue = 1'b1;
                    cnt_d = cnt_q - SPS_WIDTH'(1);
                end else if (handshake) begin
                    issue = 1'b1;
                    bit_d = bit_in_i;
                    cnt_d = sps_eff - SPS_WIDTH'(1);
                end else begin
                    underrun_d = 1'b1;
                end
            end
            default: cnt_d = '0;
        endcase
        addr_valid_d = issue;
        sym_strobe_d = issue & (cnt_d == '0);
        q_valid_d    = addr_valid_q;
        amp_gate_d   = addr_valid_q & ((mode_q != MODE_ASK) | bit_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            bit_q        <= 1'b0;
            addr_valid_q <= 1'b0;
            sym_strobe_q <= 1'b0;
            q_valid_q    <= 1'b0;
            amp_gate_q   <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            addr_valid_q <= addr_valid_d;
            sym_strobe_q <= sym_strobe_d;
            q_valid_q    <= q_valid_d;
            amp_gate_q   <= amp_gate_d;
            underrun_q   <= underrun_d;
        end
    end

    // Shadow config only updates between runs so a symbol never sees a mixed setting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q <= MODE_CARRIER;
            fcw0_q <= '0;
            fcw1_q <= '0;
            sps_q  <= SPS_WIDTH'(1);
        end else if (cfg_load_i && state_q == StIdle) begin
            mode_q <= cfg_mode_i;
            fcw0_q <= cfg_fcw0_i;
            fcw1_q <= cfg_fcw1_i;
            sps_q  <= cfg_sps_i;
        end
    end

    phase_acc #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .PHASE_WIDTH(PHASE_WIDTH)
    ) u_phase_acc (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .issue_i(issue),
        .bit_i  (bit_d),
        .mode_i (mode_q),
        .fcw0_i (fcw0_q),
        .fcw1_i (fcw1_q),
        .addr_o (rom_addr_o)
    );

    assign addr_valid_o = addr_valid_q;
    assign sym_strobe_o = sym_strobe_q;
    assign q_valid_o    = q_valid_q;
    assign amp_gate_o   = amp_gate_q;
    assign underrun_o   = underrun_q;

endmodule

// File: tb/tb_mod_phase_gen.sv
// Scoreboard bench for mod_phase_gen: a symbol-level model queues expected samples per accepted bit.
module tb_mod_phase_gen;

    localparam int AW = 8;
    localparam int PW = 24;
    localparam int SW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          cfg_load = 1'b0;
    logic [1:0]    cfg_mode = 2'b00;
    logic [PW-1:0] cfg_fcw0 = '0;
    logic [PW-1:0] cfg_fcw1 = '0;
    logic [SW-1:0] cfg_sps = 16'd1;
    logic          bit_in = 1'b0;
    logic          bit_valid = 1'b0;
    logic          bit_ready;
    logic [AW-1:0] rom_addr;
    logic          addr_valid, sym_strobe, q_valid, amp_gate, underrun;

    mod_phase_gen #(
        .ADDR_WIDTH (AW),
        .PHASE_WIDTH(PW),
        .SPS_WIDTH  (SW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .cfg_load_i  (cfg_load),
        .cfg_mode_i  (cfg_mode),
        .cfg_fcw0_i  (cfg_fcw0),
        .cfg_fcw1_i  (cfg_fcw1),
        .cfg_sps_i   (cfg_sps),
        .bit_in_i    (bit_in),
        .bit_valid_i (bit_valid),
        .bit_ready_o (bit_ready),
        .rom_addr_o  (rom_addr),
        .addr_valid_o(addr_valid),
        .sym_strobe_o(sym_strobe),
        .q_valid_o   (q_valid),
        .amp_gate_o  (amp_gate),
        .underrun_o  (underrun)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int unsigned m_phase = 0;
    int unsigned m_mode = 0, m_fcw0 = 0, m_fcw1 = 0, m_sps = 1;
    bit          m_running = 0;
    bit          pend[$];
    int          n_acc = 0;
    bit          exp_av = 0, exp_qv = 0, exp_ur = 0;
    int unsigned exp_addr_q[$];
    bit          exp_strobe_q[$];
    bit          exp_amp_q[$];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_issue();
        bit b;
        int unsigned fcw, addr;
        b    = pend.pop_front();
        fcw  = (m_mode == 2 && b) ? m_fcw1 : m_fcw0;
        addr = ((m_phase >> (PW - AW)) + ((m_mode == 3 && b) ? (1 << (AW - 1)) : 0)) % (1 << AW);
        m_phase = (m_phase + fcw) % (1 << PW);
        exp_addr_q.push_back(addr);
        exp_strobe_q.push_back(pend.size() == 0);
        exp_amp_q.push_back((m_mode != 1) || b);
        exp_av = 1;
    endtask

    // Model: one step per rising edge, from the inputs the DUT also sees.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_phase = 0; m_mode = 0; m_fcw0 = 0; m_fcw1 = 0; m_sps = 1;
            m_running = 0;
            pend.delete(); exp_addr_q.delete(); exp_strobe_q.delete(); exp_amp_q.delete();
            exp_av = 0; exp_qv = 0; exp_ur = 0;
        end else begin
            bit was_run, rdy, hs;
            was_run = m_running;
            exp_qv  = exp_av;
            exp_av  = 0;
            exp_ur  = 0;
            rdy = en && (pend.size() == 0);
            hs  = bit_valid && rdy;
            if (!en) begin
                m_running = 0;
                pend.delete();
            end else if (pend.size() != 0) begin
                m_issue();
            end else if (hs) begin
                for (int i = 0; i < ((m_sps == 0) ? 1 : int'(m_sps)); i++) pend.push_back(bit_in);
                m_running = 1;
                n_acc++;
                m_issue();
            end else if (m_running) begin
                m_running = 0;
                exp_ur = 1;
            end
            if (cfg_load && !was_run) begin
                m_mode = cfg_mode; m_fcw0 = cfg_fcw0; m_fcw1 = cfg_fcw1; m_sps = cfg_sps;
            end
        end
    end

    // Monitor: compares registered outputs on the falling edge.
    initial forever begin
        @(negedge clk);
        chk("addr_valid", addr_valid, exp_av);
        chk("underrun", underrun, exp_ur);
        chk("q_valid", q_valid, exp_qv);
        if (exp_av && exp_addr_q.size() > 0) begin
            chk("rom_addr", rom_addr, exp_addr_q.pop_front());
            chk("sym_strobe", sym_strobe, exp_strobe_q.pop_front());
        end else begin
            chk("sym_strobe_idle", sym_strobe, 0);
        end
        if (exp_qv && exp_amp_q.size() > 0) chk("amp_gate", amp_gate, exp_amp_q.pop_front());
        else chk("amp_gate_idle", amp_gate, 0);
    end

    task automatic tick();
        #1;
        chk("bit_ready", bit_ready, en && (pend.size() == 0));
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        bit_valid = 0;
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic load_cfg(input int mode, input int unsigned f0, input int unsigned f1,
                            input int unsigned sps);
        bit_valid = 0;
        cfg_mode  = mode[1:0];
        cfg_fcw0  = f0[PW-1:0];
        cfg_fcw1  = f1[PW-1:0];
        cfg_sps   = sps[SW-1:0];
        cfg_load  = 1;
        tick();
        cfg_load  = 0;
    endtask

    task automatic send(input bit b);
        int start;
        bit done;
        start     = n_acc;
        done      = 0;
        bit_valid = 1;
        bit_in    = b;
        for (int k = 0; k < 100 && !done; k++) begin
            tick();
            if (n_acc != start) done = 1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got no handshake, expected one within 100 cycles");
        end
    endtask

    task automatic wait_idle();
        bit_valid = 0;
        for (int k = 0; k < 200 && m_running; k++) tick();
        if (m_running) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: got still running, expected idle within 200 cycles");
        end
        tick();
        tick();
    endtask

    initial begin
        @(negedge clk);
        #2;
        en = 1;
        tick();
        do_reset();

        // Carrier: addresses 0..3, strobe on the last, then underrun.
        load_cfg(0, 32'h010000, 0, 4);
        send(1);
        wait_idle();

        // FSK continuity: 0,1,2,4,6,7 with ready only on last samples.
        do_reset();
        load_cfg(2, 32'h010000, 32'h020000, 2);
        send(0); send(1); send(0);
        wait_idle();

        // BPSK across wrap: run phase to 0xF00000 first.
        do_reset();
        load_cfg(0, 32'h100000, 0, 1);
        for (int i = 0; i < 15; i++) send(1);
        wait_idle();
        load_cfg(3, 32'h100000, 0, 3);
        send(1);
        wait_idle();

        // ASK gating.
        load_cfg(1, 32'h050000, 0, 2);
        send(1); send(0);
        wait_idle();

        // Enable drop mid-symbol, ignored cfg_load in RUN, then sps=0.
        load_cfg(0, 32'h030000, 0, 8);
        send(1);
        bit_valid = 0;
        tick(); tick();
        cfg_sps = 2; cfg_load = 1;
        tick();
        cfg_load = 0;
        en = 0;
        tick();
        en = 1;
        tick();
        send(0);
        wait_idle();
        load_cfg(0, 32'h030000, 0, 0);
        send(1); send(0);
        wait_idle();

        // Reset during sample 2 of 5.
        load_cfg(2, 32'h070000, 32'h0B0000, 5);
        send(1);
        bit_valid = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        tick();
        send(1);
        wait_idle();

        // Randomized rounds.
        for (int r = 0; r < 6; r++) begin
            en = 0;
            bit_valid = 0;
            tick();
            load_cfg($urandom_range(0, 3), $urandom % (1 << PW), $urandom % (1 << PW),
                     $urandom_range(0, 5));
            en = 1;
            for (int c = 0; c < 300; c++) begin
                bit_valid = ($urandom_range(0, 3) != 0);
                bit_in    = $urandom_range(0, 1);
                en        = ($urandom_range(0, 29) != 0);
                tick();
            end
            en = 1;
            wait_idle();
        end

        chk("leftover_addr", exp_addr_q.size(), 0);
        chk("leftover_amp", exp_amp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
